// File: rtl/phase_seq_monitor.sv
// -----------------------------------------------------------------------------
// phase_seq_monitor
//
// Receives the one-hot phase pulses of the CPU timing generator. It checks
// that the phases arrive strictly as P0..P(NPH-1) and then wrap back to P0.
// It also reports the accepted phase as a binary index and counts completed
// instruction cycles. Protocol faults are latched until they are acknowledged.
//
// Ports:
//   cp          clock, all state changes on the rising edge
//   clr         synchronous active-high reset, highest priority
//   p           one-hot phase pulses, bit k = phase Pk
//   gen_reset   generator idle flag; in RUN, high with p==0 is a legal resync
//   err_ack     clears a latched fault; only acted on in FAULT
//   phase_idx   binary index of the last accepted phase
//   phase_valid phase_idx was accepted on the previous edge
//   instr_done  one-cycle pulse after P(NPH-1) is accepted
//   instr_abort one-cycle pulse when a resync cuts an instruction short
//   instr_count completed instruction cycles, modulo 2^CNT_W
//   err         sticky fault flag
//   err_code    0 none, 1 dropout, 2 multiple bits, 3 wrong order
// -----------------------------------------------------------------------------
module phase_seq_monitor #(
    parameter int NPH   = 5,
    parameter int CNT_W = 16
) (
    input  logic             cp,
    input  logic             clr,
    input  logic [NPH-1:0]   p,
    input  logic             gen_reset,
    input  logic             err_ack,
    output logic [2:0]       phase_idx,
    output logic             phase_valid,
    output logic             instr_done,
    output logic             instr_abort,
    output logic [CNT_W-1:0] instr_count,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [2:0] LAST_PH = 3'(NPH - 1);

    state_t           state_q, state_d;
    logic [2:0]       exp_q, exp_d;
    logic [2:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    // Decode the pulse vector: empty, more than one bit, and the index of the
    // set bit (only meaningful when exactly one bit is set).
    logic       p_zero;
    logic       p_multi;
    logic [2:0] p_idx;
    logic [3:0] p_ones;

    always_comb begin
        p_ones = 4'd0;
        p_idx  = 3'd0;
        for (int i = 0; i < NPH; i++) begin
            if (p[i]) begin
                p_ones = p_ones + 4'd1;
                p_idx  = 3'(i);
            end
        end
        p_zero  = (p_ones == 4'd0);
        p_multi = (p_ones > 4'd1);
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        cnt_d   = cnt_q;
        err_d   = err_q;
        code_d  = code_q;

        unique case (state_q)
            ST_IDLE: begin
                if (p_zero) begin
                    state_d = ST_IDLE;
                end else if (p_multi) begin
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                end else if (p_idx == 3'd0) begin
                    idx_d   = 3'd0;
                    valid_d = 1'b1;
                    exp_d   = 3'd1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                end
            end

            ST_RUN: begin
                if (gen_reset && p_zero) begin
                    // A resync is legal. It counts as an abort only when an
                    // instruction was partly done.
                    abort_d = (exp_q != 3'd0);
                    exp_d   = 3'd0;
                    state_d = ST_IDLE;
                end else if (p_zero) begin
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                    code_d  = 2'd1;
                end else if (p_multi) begin
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                end else if (p_idx == exp_q) begin
                    idx_d   = p_idx;
                    valid_d = 1'b1;
                    if (exp_q == LAST_PH) begin
                        exp_d  = 3'd0;
                        done_d = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end else begin
                        exp_d = exp_q + 3'd1;
                    end
                end else begin
                    // A held pulse also lands here, because exp_q has
                    // already moved on to the next phase.
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                end
            end

            ST_FAULT: begin
                // Phase activity is ignored here. A P0 that arrives on the
                // same edge as the ack is not accepted.
                if (err_ack) begin
                    err_d   = 1'b0;
                    code_d  = 2'd0;
                    exp_d   = 3'd0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                exp_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge cp) begin
        if (clr) begin
            state_q <= ST_IDLE;
            exp_q   <= 3'd0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign phase_idx   = idx_q;
    assign phase_valid = valid_q;
    assign instr_done  = done_q;
    assign instr_abort = abort_q;
    assign instr_count = cnt_q;
    assign err         = err_q;
    assign err_code    = code_q;

endmodule

// File: doc/phase_seq_monitor.md
Name: phase_seq_monitor

Overview:
- Receiving end of the CPU timing-pulse interface: consumes the one-hot phase pulses p[NPH-1:0] and the generator's reset flag.
- Checks that phases arrive strictly in order P0..P(NPH-1), wrapping back to P0.
- Re-encodes the active phase as a binary index, counts completed instruction cycles and flags protocol faults for the multi-cycle control unit.

Parameters:
NPH, 5, number of phases per instruction cycle (legal range 2..8); p is NPH bits wide.
CNT_W, 16, width of the completed-cycle counter.

Ports:
cp  input  1  clock; all state updates on rising edge
clr  input  1  synchronous active-high reset
p  input  NPH  one-hot phase pulses from the timing generator (bit k = phase Pk)
gen_reset  input  1  generator reset/idle flag (high while generator counter is in its all-zero state)
err_ack  input  1  clears a latched fault; honoured only in FAULT
phase_idx  output  3  binary index of the last accepted phase
phase_valid  output  1  high when phase_idx refers to a phase accepted on the previous edge
instr_done  output  1  one-cycle pulse after P(NPH-1) is accepted
instr_abort  output  1  one-cycle pulse when a resync cuts an instruction short
instr_count  output  CNT_W  completed instruction cycles, wraps modulo 2^CNT_W
err  output  1  sticky fault flag
err_code  output  2  0 none, 1 dropout (p==0 while running), 2 multiple bits set, 3 wrong-order phase

Behaviour:
- All outputs are registered: the response to input sampled on edge N is visible after edge N (latency 1).
- Reset (clr=1 at edge): state=IDLE, expected phase=0, phase_idx=0, phase_valid=0, instr_done=0, instr_abort=0, instr_count=0, err=0, err_code=0.
  - clr has priority over every other input.
- instr_done, instr_abort and phase_valid default to 0 each cycle unless set below.
- State IDLE:
  - p==0 stays in IDLE; gen_reset is ignored here.
  - p==onehot(0): accept, phase_idx=0, phase_valid=1, expected=1, go to RUN.
  - Multiple bits set: FAULT with code 2.
  - Any other single bit: FAULT with code 3.
- State RUN, checks in priority order:
  - (a) gen_reset=1 and p==0: legal resync, go to IDLE with expected=0.
    - If expected!=0, pulse instr_abort; instr_count is unchanged.
  - (b) p==0 with gen_reset=0: FAULT, code 1.
  - (c) More than one bit set: FAULT, code 2. This applies even if gen_reset=1.
  - (d) Single bit k with k==expected: accept, phase_idx=k, phase_valid=1.
    - If k==NPH-1: expected=0, pulse instr_done, instr_count+1 (wrap to 0 past all-ones).
    - Otherwise: expected=k+1.
  - (e) Single bit k with k!=expected: FAULT, code 3.
- Entering FAULT: err=1, err_code latched, phase_valid=0. phase_idx and instr_count hold.
- State FAULT:
  - All p/gen_reset activity is ignored.
  - err_ack=1 at an edge: err=0, err_code=0, expected=0, go to IDLE. instr_count is retained.
  - err_ack outside FAULT has no effect.
- Simultaneous events:
  - clr beats err_ack.
  - In FAULT, err_ack with a legal P0 on the same edge only returns to IDLE; that P0 is not accepted.
- Reset mid-instruction clears the counter and expectation. No instr_abort pulse is produced on clr.
- Any phase pulse held for multiple cycles (same bit twice) is a wrong-order fault (code 3), since expected has already advanced.
  - Exception: NPH==1 is not supported, so the bit can never legally repeat.

Test Plan:
- Nominal: clr, then 2 idle cycles, then p=00001,00010,00100,01000,10000 repeated 3 times -> phase_idx follows 0..4 one cycle late; instr_done pulses 3 times; instr_count=3; err=0.
- Dropout: after P0,P1 drive p=00000 with gen_reset=0 -> err=1, err_code=1 on next cycle; further pulses are ignored. Then err_ack=1 -> err=0, back in IDLE; the next P0 is accepted; instr_count is unchanged.
- Order/multi faults:
  - P0 then p=00100 -> err_code=3.
  - After ack, reset, then p=00011 in IDLE -> err_code=2.
- Resync: P0,P1,P2 then gen_reset=1 with p=0 -> instr_abort pulses once, no instr_done, instr_count unchanged; P0 then restarts cleanly.
- Counter wrap with CNT_W=4: run 17 full cycles -> instr_count reads 15 then 0 then 1; no fault.
- Reset priority: assert clr and err_ack together while in FAULT with instr_count=5 -> all outputs at reset values, instr_count=0.
